axi_console_mon: RTL

AXI_CONSOLE_MON -- requirements
Module: axi_console_mon

---
 rtl/axi_console_mon.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/axi_console_mon.sv
// Passive AXI write snooper: captures single-beat console writes into a character FIFO
// and tracks end-of-test status from retire-stage writeback values or a cycle timeout.
module axi_console_mon #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h01FF_FFF0,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [63:0] PASS_VAL     = 64'h0000_0004_4433_3222,
  parameter logic [63:0] FAIL_VAL     = 64'h0000_0023_8234_8720,
  parameter logic [31:0] MAX_CYCLES   = 32'h0300_0000
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clk_en,
  input  logic         awvalid,
  input  logic         awready,
  input  logic [31:0]  awaddr,
  input  logic [3:0]   awlen,
  input  logic         wvalid,
  input  logic         wready,
  input  logic         wlast,
  input  logic [127:0] wdata,
  input  logic [15:0]  wstrb,
  input  logic [63:0]  wb0_data,
  input  logic [63:0]  wb1_data,
  output logic         char_vld,
  output logic [7:0]   char_data,
  input  logic         char_rdy,
  output logic         test_done,
  output logic         test_pass,
  output logic         timeout,
  output logic         ovf,
  output logic [15:0]  drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIT  = 2'd1;
  localparam logic [1:0] S_SKIP = 2'd2;

  logic aw_hs, w_hs;
  assign aw_hs = clk_en & awvalid & awready;
  assign w_hs  = clk_en & wvalid & wready;

  // ---------------- write-channel tracker ----------------
  logic [1:0] state, state_nxt, aw_dest;
  logic       free;

  always_comb begin
    aw_dest   = (awaddr == CONSOLE_ADDR && awlen == 4'd0) ? S_HIT : S_SKIP;
    free      = 1'b0;
    state_nxt = state;
    case (state)
      S_HIT:   free = w_hs;
      S_SKIP:  free = w_hs & wlast;
      default: free = 1'b1;
    endcase
    // A burst completing this cycle frees the tracker for an AW in the same cycle.
    if (free) state_nxt = aw_hs ? aw_dest : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- byte capture ----------------
  logic       sel_vld;
  logic [7:0] sel_byte;

  always_comb begin
    sel_vld  = 1'b1;
    sel_byte = 8'h00;
    case (wstrb)
      16'h000F: sel_byte = wdata[7:0];
      16'h00F0: sel_byte = wdata[39:32];
      16'h0F00: sel_byte = wdata[71:64];
      16'hF000: sel_byte = wdata[103:96];
      default:  sel_vld  = 1'b0;
    endcase
  end

  logic       cap_vld;
  logic [7:0] cap_byte;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cap_vld  <= 1'b0;
      cap_byte <= 8'h00;
    end else begin
      cap_vld <= (state == S_HIT) & w_hs & sel_vld;
      if ((state == S_HIT) & w_hs & sel_vld) cap_byte <= sel_byte;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wdata[127:104], wdata[95:72], wdata[63:40], wdata[31:8]};

  // ---------------- character FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, push_ok, drop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = ~empty & char_rdy;
  assign push_ok = cap_vld & (~full | pop);
  assign drop    = cap_vld & full & ~pop;

  assign char_vld  = ~empty;
  assign char_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cap_byte;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= 16'h0000;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // ---------------- end-of-test status ----------------
  logic [31:0] cyc_cnt;
  logic        pass_hit, fail_hit;

  assign pass_hit = (wb0_data == PASS_VAL) | (wb1_data == PASS_VAL);
  assign fail_hit = (wb0_data == FAIL_VAL) | (wb1_data == FAIL_VAL);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cyc_cnt   <= 32'd0;
      test_done <= 1'b0;
      test_pass <= 1'b0;
      timeout   <= 1'b0;
    end else if (!test_done) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (pass_hit) begin
        test_done <= 1'b1;
        test_pass <= 1'b1;
      end else if (fail_hit) begin
        test_done <= 1'b1;
      end else if (cyc_cnt == MAX_CYCLES - 32'd1) begin
        test_done <= 1'b1;
        timeout   <= 1'b1;
      end
    end
  end

endmodule
